dvv_sock_arb: RTL

DVV_SOCK_ARB -- requirements
Module: dvv_sock_arb

---
 rtl/dvv_sock_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dvv_sock_arb.sv
// Per-channel FIFO buffering with a round-robin arbiter feeding one registered output stage.
// Flush clears a channel's buffer but never touches the word already held in the output stage.
module dvv_sock_arb #(
    parameter int DW    = 8,
    parameter int CH    = 4,
    parameter int DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [CH-1:0]                             in_valid,
    input  logic [CH*DW-1:0]                          in_data,
    output logic [CH-1:0]                             in_ready,
    input  logic [CH-1:0]                             flush,
    output logic                                      out_valid,
    output logic [DW-1:0]                             out_data,
    output logic [(($clog2(CH) > 0) ? $clog2(CH) : 1)-1:0] out_ch,
    input  logic                                      out_ready,
    output logic [CH*($clog2(DEPTH)+1)-1:0]           level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = ($clog2(CH) > 0) ? $clog2(CH) : 1;

    logic [DW-1:0] mem_q   [CH][DEPTH];
    logic [DW-1:0] mem_d   [CH][DEPTH];
    logic [PW-1:0] wptr_q  [CH];
    logic [PW-1:0] wptr_d  [CH];
    logic [PW-1:0] rptr_q  [CH];
    logic [PW-1:0] rptr_d  [CH];
    logic [LW-1:0] level_q [CH];
    logic [LW-1:0] level_d [CH];
    logic [CW-1:0] rr_q, rr_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [CH-1:0] push, pop, nonempty;
    logic          found, load;
    logic [CW-1:0] win;
    int            idx;

    // A flushing channel is invisible to the arbiter for that cycle.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = (level_q[i] != LW'(DEPTH));
            nonempty[i] = (level_q[i] != '0) && !flush[i];
            push[i]     = in_valid[i] && in_ready[i] && !flush[i];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < CH; k++) begin
            idx = (int'(rr_q) + k) % CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
        load = (!out_valid_q || out_ready) && found;
        for (int i = 0; i < CH; i++) begin
            pop[i] = load && (win == CW'(i));
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        for (int i = 0; i < CH; i++) begin
            if (flush[i]) begin
                wptr_d[i]  = '0;
                rptr_d[i]  = '0;
                level_d[i] = '0;
            end else begin
                if (push[i]) begin
                    mem_d[i][wptr_q[i]] = in_data[i*DW +: DW];
                    wptr_d[i]           = wptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rptr_d[i] = rptr_q[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    level_d[i] = level_q[i] + LW'(1);
                end else if (!push[i] && pop[i]) begin
                    level_d[i] = level_q[i] - LW'(1);
                end
            end
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[win][rptr_q[win]];
            out_ch_d    = win;
            rr_d        = (win == CW'(CH - 1)) ? '0 : win + CW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                level_q[i] <= '0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < CH; i++) begin
            level[i*LW +: LW] = level_q[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
